// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: score entry layout, the
// end-of-song marker, FSM state encoding and entry pack/unpack helpers.
// An entry is {shift[13:12], notes[11:5], dur[4:0]}; dur = 0 marks end of song.
package song_sequencer_pkg;

    localparam int SONG_W    = 2;
    localparam int SHIFT_W   = 2;
    localparam int NOTE_W    = 7;
    localparam int DUR_W     = 5;
    localparam int ENTRY_W   = SHIFT_W + NOTE_W + DUR_W;
    localparam int DUR_LSB   = 0;
    localparam int NOTE_LSB  = DUR_LSB + DUR_W;
    localparam int SHIFT_LSB = NOTE_LSB + NOTE_W;

    localparam logic [DUR_W-1:0] DUR_END = 5'd0;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PAUSED = 3'd4
    } state_e;

    function automatic entry_t make_entry(input logic [SHIFT_W-1:0] s,
                                          input logic [NOTE_W-1:0]  n,
                                          input logic [DUR_W-1:0]   d);
        return {s, n, d};
    endfunction

    function automatic logic [DUR_W-1:0] entry_dur(input entry_t e);
        return e[DUR_LSB +: DUR_W];
    endfunction

    function automatic logic [NOTE_W-1:0] entry_notes(input entry_t e);
        return e[NOTE_LSB +: NOTE_W];
    endfunction

    function automatic logic [SHIFT_W-1:0] entry_shift(input entry_t e);
        return e[SHIFT_LSB +: SHIFT_W];
    endfunction

    localparam entry_t END_ENTRY = {SHIFT_W'(0), NOTE_W'(0), DUR_END};

endpackage

// File: rtl/song_sequencer_rom.sv
// Score ROM: 4 songs x 2**ADDR_W entries, one-cycle synchronous read.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   song_i      song number of the entry to read
//   step_i      entry index within the song
//   data_o      14-bit entry, valid the cycle after song_i/step_i are presented
// Song 0: C (2 ticks), E+G octave 1 (1 tick), end.
// Song 1: end marker only.
// Song 2: 3-note chord octave 2, one-tick rest, two-note chord octave 3, end.
// Song 3: full length, no end marker; every entry sounds for one tick.
module song_sequencer_rom
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SONG_W-1:0] song_i,
    input  logic [ADDR_W-1:0] step_i,
    output entry_t            data_o
);

    entry_t data_d;
    entry_t data_q;

    // Score table lookup.
    always_comb begin
        data_d = END_ENTRY;
        case (song_i)
            2'd0: begin
                case (step_i)
                    ADDR_W'(0): data_d = make_entry(2'd0, 7'h01, 5'd2);
                    ADDR_W'(1): data_d = make_entry(2'd1, 7'h14, 5'd1);
                    default:    data_d = END_ENTRY;
                endcase
            end
            2'd1: data_d = END_ENTRY;
            2'd2: begin
                case (step_i)
                    ADDR_W'(0): data_d = make_entry(2'd2, 7'h07, 5'd1);
                    ADDR_W'(1): data_d = make_entry(2'd0, 7'h00, 5'd1);
                    ADDR_W'(2): data_d = make_entry(2'd3, 7'h48, 5'd2);
                    default:    data_d = END_ENTRY;
                endcase
            end
            2'd3: data_d = make_entry(step_i[1:0], NOTE_W'(step_i) + 7'd1, 5'd1);
            default: data_d = END_ENTRY;
        endcase
    end

    // Synchronous read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= END_ENTRY;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/song_sequencer.sv
// Score player driving SoundTop's notes/shift inputs from a stored song.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   start           pulse: (re)start song song_sel from entry 0
//   stop            pulse: abort playback, back to idle, no done
//   pause           level: freeze playback (honoured in PLAY/GAP only)
//   loop_en         level: restart at entry 0 at end of song
//   song_sel        song number, sampled when start is accepted
//   notes, shift    to SoundTop (notes[7] always 0)
//   playing         high in FETCH/PLAY/GAP/PAUSED
//   done            one-cycle pulse when a non-looping song ends
//   step            index of the current entry
// The articulation gap between entries is GAP_CYCLES silent cycles in total:
// GAP_CYCLES-1 cycles in GAP plus the FETCH cycle of the next entry, so
// GAP_CYCLES must be at least 2. TICK_CYCLES must be at least 2.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [1:0]        song_sel,
    output logic [7:0]        notes,
    output logic [1:0]        shift,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] step
);

    localparam int TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 2);
    localparam logic [ADDR_W-1:0] STEP_LAST = {ADDR_W{1'b1}};

    state_e              state_q, state_d;
    state_e              saved_q, saved_d;
    state_e              adv_state_s;
    logic                end_s;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [NOTE_W-1:0]   ent_notes_q, ent_notes_d;
    logic [NOTE_W-1:0]   notes_q, notes_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                playing_q, playing_d;
    logic                done_q, done_d;
    entry_t              rom_data_s;

    // The ROM is addressed with next-state values so the entry for the
    // current song/step is already on rom_data_s during FETCH.
    song_sequencer_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .song_i (song_d),
        .step_i (step_d),
        .data_o (rom_data_s)
    );

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        song_d      = song_q;
        step_d      = step_q;
        tick_d      = tick_q;
        dur_d       = dur_q;
        gap_d       = gap_q;
        ent_notes_d = ent_notes_q;
        notes_d     = notes_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        end_s       = 1'b0;
        // Leaving PAUSED performs the held cycle's advance, so a pause of
        // N cycles lengthens playback by exactly N cycles.
        adv_state_s = (state_q == ST_PAUSED) ? saved_q : state_q;

        if (stop) begin
            state_d = ST_IDLE;
            notes_d = 7'd0;
            shift_d = 2'd0;
        end else if (start) begin
            state_d = ST_FETCH;
            song_d  = song_sel;
            step_d  = {ADDR_W{1'b0}};
            notes_d = 7'd0;
        end else if (pause && ((state_q == ST_PLAY) || (state_q == ST_GAP) ||
                               (state_q == ST_PAUSED))) begin
            state_d = ST_PAUSED;
            notes_d = 7'd0;
            if (state_q != ST_PAUSED) begin
                saved_d = state_q;
            end else begin
                saved_d = saved_q;
            end
        end else begin
            case (adv_state_s)
                ST_IDLE: begin
                    notes_d = 7'd0;
                end
                ST_FETCH: begin
                    if (entry_dur(rom_data_s) == DUR_END) begin
                        end_s = 1'b1;
                    end else begin
                        ent_notes_d = entry_notes(rom_data_s);
                        notes_d     = entry_notes(rom_data_s);
                        shift_d     = entry_shift(rom_data_s);
                        dur_d       = entry_dur(rom_data_s);
                        tick_d      = {TICK_W{1'b0}};
                        state_d     = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    state_d = ST_PLAY;
                    notes_d = ent_notes_q;
                    if (tick_q == TICK_LAST) begin
                        tick_d = {TICK_W{1'b0}};
                        dur_d  = dur_q - 5'd1;
                        if (dur_q == 5'd1) begin
                            state_d = ST_GAP;
                            notes_d = 7'd0;
                            gap_d   = {GAP_W{1'b0}};
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                ST_GAP: begin
                    state_d = ST_GAP;
                    notes_d = 7'd0;
                    if (gap_q == GAP_LAST) begin
                        // The last entry slot has no successor: end the song.
                        if (step_q == STEP_LAST) begin
                            end_s = 1'b1;
                        end else begin
                            step_d  = step_q + ADDR_W'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    notes_d = 7'd0;
                    shift_d = 2'd0;
                end
            endcase

            if (end_s) begin
                notes_d = 7'd0;
                if (loop_en) begin
                    step_d  = {ADDR_W{1'b0}};
                    state_d = ST_FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    shift_d = 2'd0;
                end
            end else begin
                done_d = 1'b0;
            end
        end

        playing_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            saved_q     <= ST_IDLE;
            song_q      <= 2'd0;
            step_q      <= {ADDR_W{1'b0}};
            tick_q      <= {TICK_W{1'b0}};
            dur_q       <= 5'd0;
            gap_q       <= {GAP_W{1'b0}};
            ent_notes_q <= 7'd0;
            notes_q     <= 7'd0;
            shift_q     <= 2'd0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            song_q      <= song_d;
            step_q      <= step_d;
            tick_q      <= tick_d;
            dur_q       <= dur_d;
            gap_q       <= gap_d;
            ent_notes_q <= ent_notes_d;
            notes_q     <= notes_d;
            shift_q     <= shift_d;
            playing_q   <= playing_d;
            done_q      <= done_d;
        end
    end

    assign notes   = {1'b0, notes_q};
    assign shift   = shift_q;
    assign playing = playing_q;
    assign done    = done_q;
    assign step    = step_q;

endmodule
